// File: rtl/ex_mem_stall_ctrl.sv
// Purpose : stall/flush controller that sequences the EX/MEM data-memory access
//           over a req/ack bus and drives pipeline enables and bubbles.
// Latency : >= 2 stall cycles per memory op (IDLE issue + at least one WAIT);
//           DONE releases the pipeline.
// Backpressure: the data bus back-pressures via dbus_ack; the pipeline is frozen
//           until ack or until the access is abandoned after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   ex_mem_valid/ex_mem_is_load/ex_mem_is_store : instruction held in EX/MEM
//   load_use_hazard                              : from the hazard unit
//   dbus_ack / dbus_req / dbus_we                : data-bus handshake
//   pc_enable, if_id_enable, id_ex_enable, ex_mem_enable : register enables
//   id_ex_bubble, mem_wb_bubble                  : force valid_in = 0
//   busy                                         : access outstanding
//   bus_err                                      : one-cycle timeout pulse
module ex_mem_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,  // must be >= 2
  parameter int CNT_W          = 9     // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_mem_valid,
  input  logic ex_mem_is_load,
  input  logic ex_mem_is_store,
  input  logic load_use_hazard,
  input  logic dbus_ack,
  output logic dbus_req,
  output logic dbus_we,
  output logic pc_enable,
  output logic if_id_enable,
  output logic id_ex_enable,
  output logic id_ex_bubble,
  output logic ex_mem_enable,
  output logic mem_wb_bubble,
  output logic busy,
  output logic bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             req_nxt, we_nxt, err_nxt;

  logic mem_op;
  logic mem_stall;

  assign mem_op    = ex_mem_valid & (ex_mem_is_load | ex_mem_is_store);
  assign mem_stall = ((state == IDLE) & mem_op) | (state == WAIT);

  // Next-state logic. dbus_we is only meaningful while dbus_req is high, so it
  // simply holds its value outside the issue cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_nxt      = dbus_req;
    we_nxt       = dbus_we;
    err_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        req_nxt = 1'b0;
        if (mem_op) begin
          state_nxt    = WAIT;
          req_nxt      = 1'b1;
          // A load+store encoding is treated as a store.
          we_nxt       = ex_mem_is_store;
          wait_cnt_nxt = '0;
        end
      end

      WAIT: begin
        if (dbus_ack) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = DONE;
          req_nxt   = 1'b0;
          err_nxt   = 1'b1;
        end else if (wait_cnt != CNT_MAX) begin
          // Saturating increment: never wraps even if parameters are odd.
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end

      DONE: begin
        // The finished instruction leaves EX/MEM on this edge (ex_mem_enable
        // is 1 here), so it is never reissued. Acks here are ignored.
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        err_nxt   = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      dbus_req <= 1'b0;
      dbus_we  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      dbus_req <= req_nxt;
      dbus_we  <= we_nxt;
      bus_err  <= err_nxt;
    end
  end

  // Pipeline control. A memory stall freezes everything up to EX/MEM and
  // feeds a bubble to MEM/WB; it takes priority over a load-use hazard, which
  // would otherwise push a bubble into ID/EX while EX/MEM keeps moving.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_enable = 1'b1;
    mem_wb_bubble = 1'b0;

    if (mem_stall) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (load_use_hazard) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_bubble  = 1'b1;
    end
  end

  assign busy = (state != IDLE);

endmodule
